// File: rtl/button_led_pkg.sv
// Mode encoding and advance order shared by the button/LED controller.
package button_led_pkg;

    typedef enum logic [1:0] {
        MODE_OFF  = 2'd0,
        MODE_ON   = 2'd1,
        MODE_SLOW = 2'd2,
        MODE_FAST = 2'd3
    } mode_t;

    function automatic mode_t next_mode(input mode_t m);
        case (m)
            MODE_OFF:  return MODE_ON;
            MODE_ON:   return MODE_SLOW;
            MODE_SLOW: return MODE_FAST;
            default:   return MODE_OFF;
        endcase
    endfunction

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchroniser, debounce counter and press/release pulse generation.
// The release pulse is named rel because release is a reserved word.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic in,
    output logic stable,
    output logic press,
    output logic rel
);

    localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DW-1:0] DLAST = DW'(DEBOUNCE_CYCLES - 1);

    logic          s1;
    logic          s2;
    logic          stable_q;
    logic [DW-1:0] dcnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1       <= 1'b0;
            s2       <= 1'b0;
            stable   <= 1'b0;
            stable_q <= 1'b0;
            dcnt     <= '0;
        end else begin
            s1       <= in;
            s2       <= s1;
            stable_q <= stable;
            if (s2 != stable) begin
                if (dcnt == DLAST) begin
                    stable <= ~stable;
                    dcnt   <= '0;
                end else begin
                    dcnt <= dcnt + 1'b1;
                end
            end else begin
                dcnt <= '0;
            end
        end
    end

    assign press = stable & ~stable_q;
    assign rel   = ~stable & stable_q;

endmodule

// File: rtl/button_led_ctrl.sv
// Button-driven LED mode controller: OFF / ON / SLOW blink / FAST blink.
// Optional macro BUTTON_LONG_PRESS_EN: advance on release, long hold forces OFF.
//
// state     | meaning
// MODE_OFF  | led held low
// MODE_ON   | led held high
// MODE_SLOW | led toggles every SLOW_DIV cycles, starts high
// MODE_FAST | led toggles every FAST_DIV cycles, starts high
module button_led_ctrl
    import button_led_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = 1_000_000,
    parameter int SLOW_DIV          = 25_000_000,
    parameter int FAST_DIV          = 5_000_000,
    parameter int LONG_PRESS_CYCLES = 100_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       but,
    output logic       led,
    output logic [1:0] mode
);

    localparam int MAXDIV = (SLOW_DIV > FAST_DIV) ? SLOW_DIV : FAST_DIV;
    localparam int BW     = (MAXDIV > 1) ? $clog2(MAXDIV) : 1;
    localparam logic [BW-1:0] SLOW_LAST = BW'(SLOW_DIV - 1);
    localparam logic [BW-1:0] FAST_LAST = BW'(FAST_DIV - 1);

    logic          stable;
    logic          press;
    logic          rel;
    logic          advance;
    logic          force_off;
    mode_t         state;
    mode_t         state_nx;
    mode_t         nxt;
    logic          led_nx;
    logic [BW-1:0] bcnt;
    logic [BW-1:0] bcnt_nx;
    logic [BW-1:0] div_last;

    button_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
        .clk    (clk),
        .rst    (rst),
        .in     (but),
        .stable (stable),
        .press  (press),
        .rel    (rel)
    );

`ifdef BUTTON_LONG_PRESS_EN
    // Sized to hold LONG_PRESS_CYCLES itself so the count can saturate there.
    localparam int HW = $clog2(LONG_PRESS_CYCLES + 1);
    localparam logic [HW-1:0] HSAT  = HW'(LONG_PRESS_CYCLES);
    localparam logic [HW-1:0] HLAST = HW'(LONG_PRESS_CYCLES - 1);

    logic [HW-1:0] hcnt;
    logic [HW-1:0] hcnt_nx;
    logic          latch;
    logic          latch_nx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hcnt  <= '0;
            latch <= 1'b0;
        end else begin
            hcnt  <= hcnt_nx;
            latch <= latch_nx;
        end
    end
`else
    logic unused_ok;
    assign unused_ok = ^{stable, rel, 32'(LONG_PRESS_CYCLES)};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= MODE_OFF;
            led   <= 1'b0;
            bcnt  <= '0;
        end else begin
            state <= state_nx;
            led   <= led_nx;
            bcnt  <= bcnt_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        led_nx    = led;
        bcnt_nx   = bcnt;
        nxt       = next_mode(state);
        div_last  = (state == MODE_SLOW) ? SLOW_LAST : FAST_LAST;
        force_off = 1'b0;
`ifdef BUTTON_LONG_PRESS_EN
        hcnt_nx  = hcnt;
        latch_nx = latch;
        advance  = 1'b0;
        if (rel) begin
            hcnt_nx  = '0;
            latch_nx = 1'b0;
            advance  = ~latch;
        end else if (press) begin
            hcnt_nx = '0;
        end else if (stable && hcnt != HSAT) begin
            hcnt_nx = hcnt + 1'b1;
        end
        if (stable && !latch && hcnt == HLAST) begin
            force_off = 1'b1;
            latch_nx  = 1'b1;
        end
`else
        advance = press;
`endif
        // Mode changes take priority over a coincident blink wrap.
        if (force_off) begin
            state_nx = MODE_OFF;
            led_nx   = 1'b0;
            bcnt_nx  = '0;
        end else if (advance) begin
            state_nx = nxt;
            led_nx   = (nxt != MODE_OFF);
            bcnt_nx  = '0;
        end else begin
            case (state)
                MODE_OFF: begin
                    led_nx  = 1'b0;
                    bcnt_nx = '0;
                end
                MODE_ON: begin
                    led_nx  = 1'b1;
                    bcnt_nx = '0;
                end
                default: begin
                    if (bcnt == div_last) begin
                        bcnt_nx = '0;
                        led_nx  = ~led;
                    end else begin
                        bcnt_nx = bcnt + 1'b1;
                    end
                end
            endcase
        end
    end

    assign mode = state;

endmodule

// File: tb/tb_button_led_ctrl.sv
// Directed bench for button_led_ctrl with small timing parameters.
module tb_button_led_ctrl;

    localparam int D    = 4;
    localparam int SLOW = 8;
    localparam int FAST = 2;
    localparam int LP   = 20;

    typedef struct {
        int         hi;
        int         lo;
        logic [1:0] exp_old;
        logic [1:0] exp_new;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       but;
    logic       led;
    logic [1:0] mode;

    int errors = 0;
    int checks = 0;
    int press_cnt = 0;

    always #5 clk = ~clk;

    button_led_ctrl #(
        .DEBOUNCE_CYCLES  (D),
        .SLOW_DIV         (SLOW),
        .FAST_DIV         (FAST),
        .LONG_PRESS_CYCLES(LP)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .but  (but),
        .led  (led),
        .mode (mode)
    );

    always @(posedge clk) begin
        if (dut.u_deb.press) press_cnt <= press_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic exp_led(input logic [1:0] m, input int n);
        case (m)
            2'd0:    return 1'b0;
            2'd1:    return 1'b1;
            2'd2:    return ((n / SLOW) % 2) == 0;
            default: return ((n / FAST) % 2) == 0;
        endcase
    endfunction

    // Button high for v.hi edges, low for v.lo edges; mode lands at ent.
    task automatic run_vec(input vec_t v);
        int ent;
        bit chg;
        chg = (v.exp_new != v.exp_old);
`ifdef BUTTON_LONG_PRESS_EN
        ent = v.hi + D + 3;
`else
        ent = D + 3;
`endif
        but = 1'b1;
        for (int k = 1; k <= v.hi + v.lo; k++) begin
            tick();
            if (k == v.hi) but = 1'b0;
            if (k == ent - 1) check("mode_before", mode, v.exp_old);
            if (k >= ent) begin
                check("mode_after", mode, v.exp_new);
                if (chg) check("led_pattern", led, exp_led(v.exp_new, k - ent));
            end
        end
        check("dcnt_idle", dut.u_deb.dcnt, 0);
    endtask

    vec_t vecs[5];
    int   p0;

    initial begin
        vecs[0] = '{hi: 3,  lo: 12, exp_old: 2'd0, exp_new: 2'd0};
        vecs[1] = '{hi: 10, lo: 12, exp_old: 2'd0, exp_new: 2'd1};
        vecs[2] = '{hi: 10, lo: 30, exp_old: 2'd1, exp_new: 2'd2};
        vecs[3] = '{hi: 10, lo: 14, exp_old: 2'd2, exp_new: 2'd3};
        vecs[4] = '{hi: 10, lo: 12, exp_old: 2'd3, exp_new: 2'd0};

        rst = 1'b1;
        but = 1'b0;
        tick();
        check("reset_mode", mode, 0);
        check("reset_led", led, 0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            check("idle_mode", mode, 0);
            check("idle_led", led, 0);
        end

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Bouncing contact, then a clean hold: one press, one step.
        p0 = press_cnt;
        for (int i = 0; i < 12; i++) begin
            but = (i % 2 == 0);
            tick();
            check("bounce_no_step", mode, 0);
        end
        but = 1'b1;
        for (int i = 0; i < 12; i++) tick();
        but = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        check("bounce_press_count", press_cnt - p0, 1);
        check("bounce_mode", mode, 1);

        // Reset while in SLOW with the button held; held button is re-debounced.
        run_vec('{hi: 10, lo: 12, exp_old: 2'd1, exp_new: 2'd2});
        but = 1'b1;
        tick();
        tick();
        #2 rst = 1'b1;
        #1;
        check("async_reset_mode", mode, 0);
        check("async_reset_led", led, 0);
        tick();
        rst = 1'b0;
        for (int k = 1; k <= D + 3; k++) begin
            tick();
            if (k == D + 2) check("held_pre_mode", mode, 0);
        end
`ifdef BUTTON_LONG_PRESS_EN
        check("held_press_mode", mode, 0);
        but = 1'b0;
        for (int k = 1; k <= D + 3; k++) begin
            tick();
            if (k == D + 2) check("held_rel_pre", mode, 0);
        end
        check("held_rel_mode", mode, 1);
        check("held_rel_led", led, 1);
`else
        check("held_press_mode", mode, 1);
        check("held_press_led", led, 1);
        but = 1'b0;
`endif
        for (int i = 0; i < 15; i++) tick();

        // 30-cycle hold from SLOW.
        run_vec('{hi: 10, lo: 12, exp_old: 2'd1, exp_new: 2'd2});
        but = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            tick();
`ifdef BUTTON_LONG_PRESS_EN
            if (k == 26) check("long_pre_mode", mode, 2);
            if (k == 27) begin
                check("long_force_mode", mode, 0);
                check("long_force_led", led, 0);
            end
`else
            if (k == 26) check("hold_mode", mode, 3);
`endif
        end
        but = 1'b0;
        for (int i = 0; i < 20; i++) tick();
`ifdef BUTTON_LONG_PRESS_EN
        check("long_release_ignored", mode, 0);
`else
        check("hold_release_mode", mode, 3);
`endif
        check("final_dcnt", dut.u_deb.dcnt, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
